dm_responder: RTL

Memory-side responder for the CPU data port: accepts one load/store request at a time over a valid/ready handshake, inserts a fixed number of wait states, and returns a single response carrying read data and an error flag. Sits between the datapath's memory-access stage and the on-chip data RAM. It is the slave end of the data-port protocol the core initiates, letting the core move from a zero-latency combinational RAM to a stall-capable bus.

---
 rtl/dm_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dm_responder.sv
// Data-port memory responder: one request at a time, fixed wait states, single response.
// Optional address checking is compiled in with `define DM_ADDR_CHECK_EN.
module dm_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned WAIT       = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_done;
  logic                  w_hs;
  logic                  w_err;
  logic [DEPTH_LOG2-1:0] w_idx;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_done   = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_hs     = (r_state == S_RESP) && rsp_ready;

`ifdef DM_ADDR_CHECK_EN
  localparam logic [32:0] SPAN = 33'd4 << DEPTH_LOG2;
  logic [31:0] w_off;
  logic [1:0]  w_unused_off;
  assign w_off        = r_addr - BASE_ADDR;
  assign w_err        = (r_addr[1:0] != 2'b00) || ({1'b0, w_off} >= SPAN);
  assign w_idx        = w_off[DEPTH_LOG2+1:2];
  assign w_unused_off = w_off[1:0];
`else
  logic w_unused_addr;
  assign w_err         = 1'b0;
  assign w_idx         = r_addr[DEPTH_LOG2+1:2];
  assign w_unused_addr = ^{r_addr[31:DEPTH_LOG2+2], r_addr[1:0], BASE_ADDR};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // WAIT=0 still spends one cycle in S_WAIT so the response always lands WAIT+1 edges after accept.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP);
    rsp_rdata = r_rdata;
    rsp_err   = r_err;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 4'(WAIT);
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done) begin
        r_err   <= w_err;
        r_rdata <= (r_we || w_err) ? '0 : r_mem[w_idx];
      end
      if (w_hs) begin
        r_cnt <= '0;
      end
    end
  end

  // RAM is never reset; an asynchronous reset in S_WAIT clears r_state before the edge, dropping the store.
  always_ff @(posedge clk) begin
    if (w_done && r_we && !w_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (r_be[b]) r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

endmodule
